instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Instruction fetch stage sitting directly upstream of the instruction decode stage. It generates sequential fetch addresses, issues them to the instruction memory over a valid/ready request channel, and buffers in-order 16-bit responses in a prefetch FIFO. It presents instruction+PC to decode with a valid/ready handshake. A redirect input restarts fetch at a new PC and discards stale in-flight data.

Parameters:
ADDR_W, 8, PC / instruction-memory word-address width
FIFO_DEPTH, 4, prefetch FIFO entries and maximum in-flight requests; power of 2, >=2
RESET_PC, 0, first fetch address after reset

Ports:
IF_clock  in  1  clock, all state on rising edge
IF_reset  in  1  asynchronous, active-low reset
IF_redirect  in  1  restart fetch at IF_redirect_pc this cycle
IF_redirect_pc  in  ADDR_W  redirect target
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  word address of request
imem_rsp_valid  in  1  response data valid (in order, >=1 cycle after accept)
imem_rsp_data  in  16  fetched instruction
IF_out_valid  out  1  IF_instruction/IF_pc valid to decode
IF_out_ready  in  1  decode consumes this cycle
IF_instruction  out  16  [15:12] opcode, [11:6] param1, [5:0] param2
IF_pc  out  ADDR_W  address of IF_instruction

Behaviour:
- Reset (IF_reset=0, async): FSM=IDLE, fetch_pc=RESET_PC, rsp_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0; all outputs 0.
- FSM states: IDLE -> FETCH unconditionally on the first clock after reset release (no request in IDLE). FETCH -> FLUSH on IF_redirect when effective drop_cnt>0; otherwise stays FETCH. FLUSH -> FETCH when drop_cnt reaches 0; a redirect in FLUSH reloads pc and recomputes drop_cnt.
- Credit rule: imem_req_valid=1 only in FETCH, no IF_redirect this cycle, and (outstanding + fifo_count) < FIFO_DEPTH. imem_req_addr=fetch_pc.
- Accept (req_valid & req_ready): fetch_pc <= fetch_pc+1, mod 2^ADDR_W (wraps max -> 0); outstanding +1.
- Response: outstanding -1. If drop_cnt>0: discarded, drop_cnt -1. Else pushed with rsp_pc; rsp_pc <= rsp_pc+1 (same wrap). FIFO never overflows by credit rule; a push to a full FIFO is a design error (assertion).
- Output: IF_out_valid = FIFO non-empty; head shown combinationally; pop on valid & ready. Held stable while valid & !ready. Push and pop same cycle allowed, count unchanged; push into empty FIFO visible next cycle (1-cycle min latency rsp -> out).
- Redirect (priority over everything): FIFO flushed (no pop counted), fetch_pc <= IF_redirect_pc, rsp_pc <= IF_redirect_pc, drop_cnt <= outstanding (after this cycle's accept/response accounting) so every in-flight response is dropped; a response arriving in the redirect cycle is discarded. No request issued in redirect cycle. IF_out_valid is 0 the cycle after redirect.
- Redirect with outstanding=0: goes directly FETCH, first request next cycle at target.
- Reset mid-operation: immediate return to reset state; in-flight memory responses after reset release must not occur (memory reset together).

Optional Feature:
IF_ILLEGAL_OP_CHECK_EN: when defined, adds output IF_illegal (1 bit) = IF_out_valid & (IF_instruction[15:12] > 4'd12); reset 0; flagged instructions still delivered normally. When undefined, port and logic absent; behaviour otherwise identical.

Decomposition:
- Package instr_pkg: INSTR_W=16, OPCODE_W=4, PARAM_W=6, field bit positions, MAX_LEGAL_OPCODE=4'd12, fetch FSM state enum {IDLE, FETCH, FLUSH}.
- One sub-module: instr_fetch_fifo (depth FIFO_DEPTH, width 16+ADDR_W, push/pop/flush, count output).

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory, IF_out_ready=1 -> addresses 0,1,2,... issued back-to-back; IF_pc 0,1,2 with matching data, first IF_out_valid 3 cycles after reset release.
- IF_out_ready=0 for 20 cycles -> exactly FIFO_DEPTH=4 requests issued then imem_req_valid=0; head stays PC 0 stable; release -> 4 delivered in order, fetching resumes.
- 3 outstanding (memory latency 3) then IF_redirect to 0x40 -> 3 stale responses dropped, FSM in FLUSH, next delivered IF_pc=0x40.
- Redirect in same cycle as response arrival and decode pop -> response discarded, FIFO empty next cycle, no duplicate or lost PC after target.
- RESET_PC=0xFE -> fetch 0xFE, 0xFF, 0x00 wrap; IF_pc matches.
- IF_ILLEGAL_OP_CHECK_EN: data 0xD000 -> IF_illegal=1; 0xC000 -> 0; asynchronous reset asserted mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared definitions for the instruction fetch stage: instruction field layout
// and the fetch FSM state encoding.
package instr_pkg;

    localparam int INSTR_W    = 16;
    localparam int OPCODE_W   = 4;
    localparam int PARAM_W    = 6;
    localparam int OPCODE_LSB = 12;
    localparam int PARAM1_LSB = 6;
    localparam int PARAM2_LSB = 0;

    localparam logic [OPCODE_W-1:0] MAX_LEGAL_OPCODE = 4'd12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_LSB +: OPCODE_W];
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response channel between the fetch stage (master)
// and the instruction memory (slave).
interface instr_fetch_if #(
    parameter int ADDR_W = 8
);
    import instr_pkg::*;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Prefetch FIFO holding {pc, instruction} pairs; power-of-2 depth, synchronous
// flush, head presented combinationally.
module instr_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                   IF_clock,
    input  logic                   IF_reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop, full;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; only pointers and count do, and an entry is
    // never read before it has been written.
    always_ff @(posedge IF_clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge IF_clock or negedge IF_reset) begin
        if (!IF_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Credit accounting upstream makes a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge IF_clock) disable iff (!IF_reset)
        !(do_push && full));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: credit-limited sequential fetch, in-order prefetch
// buffering and redirect with stale-response dropping.
// Optional feature macro: IF_ILLEGAL_OP_CHECK_EN adds the IF_illegal output.
module instr_fetch
    import instr_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int RESET_PC   = 0
) (
    input  logic                IF_clock,
    input  logic                IF_reset,
    input  logic                IF_redirect,
    input  logic [ADDR_W-1:0]   IF_redirect_pc,
    instr_fetch_if.master       imem,
    output logic                IF_out_valid,
    input  logic                IF_out_ready,
    output logic [INSTR_W-1:0]  IF_instruction,
    output logic [ADDR_W-1:0]   IF_pc
`ifdef IF_ILLEGAL_OP_CHECK_EN
    ,
    output logic                IF_illegal
`endif
);
    localparam int                CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
    localparam logic [CNT_W:0]    CREDITS = (CNT_W + 1)'(FIFO_DEPTH);

    fetch_state_e                state, state_next;
    logic [ADDR_W-1:0]           fetch_pc, rsp_pc;
    logic [CNT_W-1:0]            outstanding, outstanding_next;
    logic [CNT_W-1:0]            drop_cnt, drop_cnt_next;
    logic [CNT_W-1:0]            fifo_count;
    logic                        req_valid, accept, rsp_keep, pop, fifo_empty;
    logic [INSTR_W+ADDR_W-1:0]   fifo_head;

    // NOTE: every signal driven in an always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        req_valid = (state == FETCH) && !IF_redirect &&
                    (({1'b0, outstanding} + {1'b0, fifo_count}) < CREDITS);
        accept           = req_valid && imem.imem_req_ready;
        outstanding_next = outstanding + CNT_W'(accept) - CNT_W'(imem.imem_rsp_valid);
        rsp_keep         = imem.imem_rsp_valid && (drop_cnt == '0) && !IF_redirect;
        pop              = IF_out_valid && IF_out_ready && !IF_redirect;

        drop_cnt_next = drop_cnt;
        if (IF_redirect) begin
            // Everything still in flight after this cycle belongs to the old stream.
            drop_cnt_next = outstanding_next;
        end else if (imem.imem_rsp_valid && (drop_cnt != '0)) begin
            drop_cnt_next = drop_cnt - CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = FETCH;
            FETCH:   if (IF_redirect && (outstanding_next != '0)) state_next = FLUSH;
            FLUSH:   if (drop_cnt_next == '0) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge IF_clock or negedge IF_reset) begin
        if (!IF_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge IF_clock or negedge IF_reset) begin
        if (!IF_reset) begin
            fetch_pc    <= PC_INIT;
            rsp_pc      <= PC_INIT;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            drop_cnt    <= drop_cnt_next;
            if (IF_redirect) begin
                fetch_pc <= IF_redirect_pc;
                rsp_pc   <= IF_redirect_pc;
            end else begin
                if (accept)   fetch_pc <= fetch_pc + ADDR_W'(1);
                if (rsp_keep) rsp_pc   <= rsp_pc + ADDR_W'(1);
            end
        end
    end

    instr_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INSTR_W + ADDR_W)
    ) u_fifo (
        .IF_clock  (IF_clock),
        .IF_reset  (IF_reset),
        .push      (rsp_keep),
        .push_data ({rsp_pc, imem.imem_rsp_data}),
        .pop       (pop),
        .flush     (IF_redirect),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Data outputs are forced to zero when not valid so nothing stale leaks out.
    assign IF_out_valid        = !fifo_empty;
    assign IF_instruction      = IF_out_valid ? fifo_head[INSTR_W-1:0] : '0;
    assign IF_pc               = IF_out_valid ? fifo_head[INSTR_W +: ADDR_W] : '0;
    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = req_valid ? fetch_pc : '0;

`ifdef IF_ILLEGAL_OP_CHECK_EN
    assign IF_illegal = IF_out_valid && (opcode_of(IF_instruction) > MAX_LEGAL_OPCODE);
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: two instances (RESET_PC 0 and 0xFE),
// each with its own in-order instruction memory model.
module tb_instr_fetch;
    import instr_pkg::*;

    localparam int AW = 8;

    logic          IF_clock, IF_reset;
    logic          IF_redirect, IF_out_ready;
    logic [AW-1:0] IF_redirect_pc;
    logic          IF_out_valid;
    logic [15:0]   IF_instruction;
    logic [AW-1:0] IF_pc;

    logic          b_redirect, b_out_ready;
    logic [AW-1:0] b_redirect_pc;
    logic          b_out_valid;
    logic [15:0]   b_instruction;
    logic [AW-1:0] b_pc;

`ifdef IF_ILLEGAL_OP_CHECK_EN
    logic IF_illegal, b_illegal;
`endif

    instr_fetch_if #(.ADDR_W(AW)) imem_a ();
    instr_fetch_if #(.ADDR_W(AW)) imem_b ();

    instr_fetch #(.ADDR_W(AW), .FIFO_DEPTH(4), .RESET_PC(0)) dut_a (
        .IF_clock       (IF_clock),
        .IF_reset       (IF_reset),
        .IF_redirect    (IF_redirect),
        .IF_redirect_pc (IF_redirect_pc),
        .imem           (imem_a),
        .IF_out_valid   (IF_out_valid),
        .IF_out_ready   (IF_out_ready),
        .IF_instruction (IF_instruction),
        .IF_pc          (IF_pc)
`ifdef IF_ILLEGAL_OP_CHECK_EN
        ,
        .IF_illegal     (IF_illegal)
`endif
    );

    instr_fetch #(.ADDR_W(AW), .FIFO_DEPTH(4), .RESET_PC(8'hFE)) dut_b (
        .IF_clock       (IF_clock),
        .IF_reset       (IF_reset),
        .IF_redirect    (b_redirect),
        .IF_redirect_pc (b_redirect_pc),
        .imem           (imem_b),
        .IF_out_valid   (b_out_valid),
        .IF_out_ready   (b_out_ready),
        .IF_instruction (b_instruction),
        .IF_pc          (b_pc)
`ifdef IF_ILLEGAL_OP_CHECK_EN
        ,
        .IF_illegal     (b_illegal)
`endif
    );

    initial IF_clock = 1'b0;
    always #5 IF_clock = ~IF_clock;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_data(input logic [AW-1:0] a);
        if (a == 8'h10) return 16'hD000;
        if (a == 8'h11) return 16'hC000;
        return {8'h3C, a};
    endfunction

    // Memory A: in-order, configurable latency; also records every delivery.
    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } mreq_t;

    mreq_t         mq[$];
    int            cyc        = 0;
    int            mem_lat    = 1;
    int            accepted_a = 0;
    logic [AW-1:0] deliv_pc[$];
    logic [15:0]   deliv_ins[$];

    initial begin
        imem_a.imem_req_ready = 1'b1;
        imem_a.imem_rsp_valid = 1'b0;
        imem_a.imem_rsp_data  = 16'h0;
        forever begin
            @(posedge IF_clock);
            cyc++;
            if (!IF_reset) begin
                mq.delete();
            end else begin
                if (imem_a.imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
                if (imem_a.imem_req_valid && imem_a.imem_req_ready) begin
                    mq.push_back('{addr: imem_a.imem_req_addr, due: cyc + mem_lat});
                    accepted_a++;
                end
                if (IF_out_valid && IF_out_ready && !IF_redirect) begin
                    deliv_pc.push_back(IF_pc);
                    deliv_ins.push_back(IF_instruction);
                end
            end
            #1;
            if (IF_reset && mq.size() > 0 && mq[0].due <= cyc + 1) begin
                imem_a.imem_rsp_valid = 1'b1;
                imem_a.imem_rsp_data  = mem_data(mq[0].addr);
            end else begin
                imem_a.imem_rsp_valid = 1'b0;
                imem_a.imem_rsp_data  = 16'h0;
            end
        end
    end

    // Memory B: always ready, fixed one-cycle latency.
    initial begin
        logic          pend;
        logic [AW-1:0] paddr;
        pend  = 1'b0;
        paddr = '0;
        imem_b.imem_req_ready = 1'b1;
        imem_b.imem_rsp_valid = 1'b0;
        imem_b.imem_rsp_data  = 16'h0;
        forever begin
            @(posedge IF_clock);
            pend  = IF_reset && imem_b.imem_req_valid;
            paddr = imem_b.imem_req_addr;
            #1;
            imem_b.imem_rsp_valid = pend;
            imem_b.imem_rsp_data  = pend ? mem_data(paddr) : 16'h0;
        end
    end

    task automatic step();
        @(negedge IF_clock);
    endtask

    // Returns at the negedge where reset is released; the next rising edge is E1.
    task automatic apply_reset(input int lat, input logic ready);
        @(negedge IF_clock);
        IF_reset     = 1'b0;
        IF_redirect  = 1'b0;
        IF_out_ready = ready;
        mem_lat      = lat;
        accepted_a   = 0;
        deliv_pc.delete();
        deliv_ins.delete();
        repeat (2) step();
        IF_reset = 1'b1;
    endtask

    initial begin
        IF_reset       = 1'b0;
        IF_redirect    = 1'b0;
        IF_redirect_pc = '0;
        IF_out_ready   = 1'b1;
        b_redirect     = 1'b0;
        b_redirect_pc  = '0;
        b_out_ready    = 1'b1;

        // Reset state
        #2;
        check("rst_req_valid", 32'(imem_a.imem_req_valid), 32'd0);
        check("rst_req_addr", 32'(imem_a.imem_req_addr), 32'd0);
        check("rst_out_valid", 32'(IF_out_valid), 32'd0);
        check("rst_instr", 32'(IF_instruction), 32'd0);
        check("rst_pc", 32'(IF_pc), 32'd0);
        check("rst_state", 32'(dut_a.state), 32'(IDLE));
        check("rst_b_req_addr", 32'(imem_b.imem_req_addr), 32'd0);
`ifdef IF_ILLEGAL_OP_CHECK_EN
        check("rst_illegal", 32'(IF_illegal), 32'd0);
`endif

        // Streaming from reset, 1-cycle memory; dut_b wraps 0xFE -> 0xFF -> 0x00
        apply_reset(1, 1'b1);
        step(); // E1
        check("s1_req_valid", 32'(imem_a.imem_req_valid), 32'd1);
        check("s1_req_addr", 32'(imem_a.imem_req_addr), 32'h00);
        check("s1_out_valid", 32'(IF_out_valid), 32'd0);
        check("w1_req_addr", 32'(imem_b.imem_req_addr), 32'hFE);
        step(); // E2
        check("s2_req_addr", 32'(imem_a.imem_req_addr), 32'h01);
        check("s2_out_valid", 32'(IF_out_valid), 32'd0);
        check("w2_req_addr", 32'(imem_b.imem_req_addr), 32'hFF);
        step(); // E3
        check("s3_out_valid", 32'(IF_out_valid), 32'd1);
        check("s3_pc", 32'(IF_pc), 32'h00);
        check("s3_instr", 32'(IF_instruction), 32'h3C00);
        check("s3_req_addr", 32'(imem_a.imem_req_addr), 32'h02);
        check("w3_req_addr", 32'(imem_b.imem_req_addr), 32'h00);
        check("w3_pc", 32'(b_pc), 32'hFE);
        check("w3_instr", 32'(b_instruction), 32'h3CFE);
        step(); // E4
        check("s4_pc", 32'(IF_pc), 32'h01);
        check("s4_instr", 32'(IF_instruction), 32'h3C01);
        check("s4_req_addr", 32'(imem_a.imem_req_addr), 32'h03);
        check("w4_pc", 32'(b_pc), 32'hFF);
        step(); // E5
        check("s5_pc", 32'(IF_pc), 32'h02);
        check("w5_pc", 32'(b_pc), 32'h00);
        check("w5_instr", 32'(b_instruction), 32'h3C00);

        // Decode stalled: exactly FIFO_DEPTH requests, head held at PC 0
        apply_reset(1, 1'b0);
        repeat (10) step();
        check("stall10_pc", 32'(IF_pc), 32'h00);
        repeat (10) step();
        check("stall_accepted", 32'(accepted_a), 32'd4);
        check("stall_req_valid", 32'(imem_a.imem_req_valid), 32'd0);
        check("stall_out_valid", 32'(IF_out_valid), 32'd1);
        check("stall20_pc", 32'(IF_pc), 32'h00);
        check("stall20_instr", 32'(IF_instruction), 32'h3C00);
        IF_out_ready = 1'b1;
        repeat (12) step();
        check("stall_deliv_cnt_ge6", 32'(deliv_pc.size() >= 6), 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (i < deliv_pc.size()) begin
                check($sformatf("stall_deliv_pc%0d", i), 32'(deliv_pc[i]), 32'(i));
                check($sformatf("stall_deliv_ins%0d", i), 32'(deliv_ins[i]), 32'h3C00 + 32'(i));
            end
        end

        // Redirect to 0x40 with three requests in flight (latency 3)
        apply_reset(3, 1'b1);
        repeat (4) step(); // E4
        check("rd_accepted", 32'(accepted_a), 32'd3);
        check("rd_out_valid_pre", 32'(IF_out_valid), 32'd0);
        IF_redirect    = 1'b1;
        IF_redirect_pc = 8'h40;
        step(); // E5: redirect edge, response 0 discarded
        check("rd_state_flush", 32'(dut_a.state), 32'(FLUSH));
        check("rd_out_valid_post", 32'(IF_out_valid), 32'd0);
        IF_redirect = 1'b0;
        #1;
        check("rd_flush_req_valid", 32'(imem_a.imem_req_valid), 32'd0);
        step(); // E6
        check("rd_state_flush2", 32'(dut_a.state), 32'(FLUSH));
        step(); // E7: last stale response dropped
        check("rd_state_fetch", 32'(dut_a.state), 32'(FETCH));
        check("rd_req_addr", 32'(imem_a.imem_req_addr), 32'h40);
        repeat (10) step();
        check("rd_deliv_cnt_ge2", 32'(deliv_pc.size() >= 2), 32'd1);
        if (deliv_pc.size() >= 2) begin
            check("rd_deliv_pc0", 32'(deliv_pc[0]), 32'h40);
            check("rd_deliv_ins0", 32'(deliv_ins[0]), 32'h3C40);
            check("rd_deliv_pc1", 32'(deliv_pc[1]), 32'h41);
        end

        // Redirect coinciding with a response and a decode handshake
        apply_reset(1, 1'b1);
        repeat (6) step(); // E6
        check("rc_pc_pre", 32'(IF_pc), 32'h03);
        check("rc_rsp_pending", 32'(imem_a.imem_rsp_valid), 32'd1);
        IF_redirect    = 1'b1;
        IF_redirect_pc = 8'h80;
        step(); // E7
        check("rc_out_valid_post", 32'(IF_out_valid), 32'd0);
        check("rc_state", 32'(dut_a.state), 32'(FETCH));
        IF_redirect = 1'b0;
        #1;
        check("rc_req_valid", 32'(imem_a.imem_req_valid), 32'd1);
        check("rc_req_addr", 32'(imem_a.imem_req_addr), 32'h80);
        repeat (10) step();
        check("rc_deliv_cnt_ge6", 32'(deliv_pc.size() >= 6), 32'd1);
        if (deliv_pc.size() >= 6) begin
            check("rc_deliv2", 32'(deliv_pc[2]), 32'h02);
            check("rc_deliv3", 32'(deliv_pc[3]), 32'h80);
            check("rc_deliv4", 32'(deliv_pc[4]), 32'h81);
            check("rc_deliv5", 32'(deliv_pc[5]), 32'h82);
            check("rc_deliv5_ins", 32'(deliv_ins[5]), 32'h3C82);
        end

        // Redirect with nothing in flight, opcode range check, async reset mid-burst
        apply_reset(1, 1'b1);
        step(); // E1
        IF_redirect    = 1'b1;
        IF_redirect_pc = 8'h10;
        step(); // E2
        check("ro_out_valid", 32'(IF_out_valid), 32'd0);
        IF_redirect = 1'b0;
        #1;
        check("ro_req_valid", 32'(imem_a.imem_req_valid), 32'd1);
        check("ro_req_addr", 32'(imem_a.imem_req_addr), 32'h10);
        step(); // E3
        step(); // E4
        check("op_pc_d", 32'(IF_pc), 32'h10);
        check("op_instr_d", 32'(IF_instruction), 32'hD000);
`ifdef IF_ILLEGAL_OP_CHECK_EN
        check("op_illegal_d", 32'(IF_illegal), 32'd1);
`endif
        step(); // E5
        check("op_pc_c", 32'(IF_pc), 32'h11);
        check("op_instr_c", 32'(IF_instruction), 32'hC000);
`ifdef IF_ILLEGAL_OP_CHECK_EN
        check("op_illegal_c", 32'(IF_illegal), 32'd0);
`endif
        step(); // E6
        check("op_pc_next", 32'(IF_pc), 32'h12);
        #2;
        IF_reset = 1'b0;
        #1;
        check("ar_req_valid", 32'(imem_a.imem_req_valid), 32'd0);
        check("ar_req_addr", 32'(imem_a.imem_req_addr), 32'd0);
        check("ar_out_valid", 32'(IF_out_valid), 32'd0);
        check("ar_instr", 32'(IF_instruction), 32'd0);
        check("ar_pc", 32'(IF_pc), 32'd0);
        check("ar_state", 32'(dut_a.state), 32'(IDLE));
        check("ar_b_out_valid", 32'(b_out_valid), 32'd0);
        check("ar_b_req_valid", 32'(imem_b.imem_req_valid), 32'd0);
`ifdef IF_ILLEGAL_OP_CHECK_EN
        check("ar_illegal", 32'(IF_illegal), 32'd0);
`endif
        repeat (2) step();
        IF_reset = 1'b1;
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
